// File: rtl/display_scan_driver_if.sv
// Bus between the datapath result registers and the display scan driver.
// load is a one-cycle strobe with no backpressure: the driver accepts it on every cycle it is high.
interface display_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] value_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  blank_lz;
  logic [3:0]            bcd_out;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   an_n;
  logic                  frame_done;

  modport master (
    output value_in, dp_in, load, blank_lz,
    input  bcd_out, dp_n, an_n, frame_done
  );

  modport slave (
    input  value_in, dp_in, load, blank_lz,
    output bcd_out, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-synchronous data commit
// and optional leading-zero blanking.
module display_scan_driver #(
  parameter int N_DIGITS        = 8,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int DEADTIME_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  display_scan_driver_if.slave  bus,
  output logic                  state_dbg
);
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEADTIME_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE = N_DIGITS'(1);

  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d, shd_val_q, shd_val_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
  logic                  pending_q, pending_d;
  logic                  lz_q, lz_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;
  logic                  slot_end, commit, upper_nz, digit_blank;
  logic [3:0]            nib;
  logic                  dp_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      pending_q <= 1'b0;
      lz_q      <= 1'b0;
      an_q      <= '1;
      bcd_q     <= 4'hF;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      shd_val_q <= shd_val_d;
      shd_dp_q  <= shd_dp_d;
      pending_q <= pending_d;
      lz_q      <= lz_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == DEAD_LAST) state_d = ST_ON;
      ST_ON:    if (cnt_q == CNT_LAST)  state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    slot_end = (state_q == ST_ON) && (cnt_q == CNT_LAST);
    commit   = slot_end && (idx_q == IDX_LAST);
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
    lz_d     = slot_end ? bus.blank_lz : lz_q;

    shd_val_d = bus.load ? bus.value_in : shd_val_q;
    shd_dp_d  = bus.load ? bus.dp_in    : shd_dp_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    pending_d = pending_q;
    if (commit) begin
      // A load landing on the commit cycle bypasses the shadow and goes straight to display.
      pending_d = 1'b0;
      if (bus.load) begin
        act_val_d = bus.value_in;
        act_dp_d  = bus.dp_in;
      end else if (pending_q) begin
        act_val_d = shd_val_q;
        act_dp_d  = shd_dp_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    // Digit data is looked up with next-cycle values so a commit shows up on digit 0 at once.
    nib    = act_val_d[int'(idx_d)*4 +: 4];
    dp_bit = act_dp_d[idx_d];
    upper_nz = 1'b0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((j >= int'(idx_d)) && ((act_val_d[j*4 +: 4] != 4'h0) || act_dp_d[j]))
        upper_nz = 1'b1;
    end
    digit_blank = lz_d && (idx_d != '0) && !upper_nz;

    an_d  = an_q;
    bcd_d = bcd_q;
    dp_d  = dp_q;
    if (state_d != state_q) begin
      bcd_d = digit_blank ? 4'hF : nib;
      dp_d  = digit_blank ? 1'b1 : ~dp_bit;
      an_d  = ((state_d == ST_ON) && !digit_blank) ? ~(ONE << idx_d) : '1;
    end
    fd_d = (state_d == ST_ON) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  assign bus.an_n       = an_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = fd_q;
  assign state_dbg      = (state_q == ST_ON);
endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with N_DIGITS=4, REFRESH_CYCLES=8, DEADTIME_CYCLES=2.
module tb_display_scan_driver;
  logic clk;
  logic rst;
  logic state_dbg;
  int   n_cmp;
  int   n_err;

  display_scan_driver_if #(.N_DIGITS(4)) bus ();

  display_scan_driver #(
    .N_DIGITS(4), .REFRESH_CYCLES(8), .DEADTIME_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL wait_frame: frame_done never seen within 40 cycles");
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    step(1);
    bus.load     = 1'b0;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic [3:0] onehot_n(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_cmp += 5;
    if (bus.an_n !== 4'hF)     begin n_err++; $display("FAIL reset_an: got %b want 1111", bus.an_n); end
    if (bus.bcd_out !== 4'hF)  begin n_err++; $display("FAIL reset_bcd: got %h want f", bus.bcd_out); end
    if (bus.dp_n !== 1'b1)     begin n_err++; $display("FAIL reset_dp: got %b want 1", bus.dp_n); end
    if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
    if (state_dbg !== 1'b0)    begin n_err++; $display("FAIL reset_state: got %b want 0", state_dbg); end
  endtask

  // Release reset, load 1234 at cycle 5, check every cycle of the first two frames.
  task automatic test_scan_load();
    logic [3:0] e_an, e_bcd;
    logic       e_fd;
    int         pos, d;
    rst = 1'b0;
    for (int c = 0; c < 64; c++) begin
      bus.load = (c == 5);
      bus.value_in = 16'h1234;
      bus.dp_in = 4'b0000;
      pos   = c % 8;
      d     = (c / 8) % 4;
      e_an  = (pos < 2) ? 4'hF : onehot_n(d);
      e_bcd = (c < 2) ? 4'hF : (c < 32) ? 4'h0 : nib(16'h1234, d);
      e_fd  = ((c % 32) == 31);
      n_cmp += 4;
      if (bus.an_n !== e_an)      begin n_err++; $display("FAIL scan_an c=%0d: got %b want %b", c, bus.an_n, e_an); end
      if (bus.bcd_out !== e_bcd)  begin n_err++; $display("FAIL scan_bcd c=%0d: got %h want %h", c, bus.bcd_out, e_bcd); end
      if (bus.dp_n !== 1'b1)      begin n_err++; $display("FAIL scan_dp c=%0d: got %b want 1", c, bus.dp_n); end
      if (bus.frame_done !== e_fd) begin n_err++; $display("FAIL scan_fd c=%0d: got %b want %b", c, bus.frame_done, e_fd); end
      step(1);
    end
    bus.load = 1'b0;
  endtask

  // Two loads within one frame: display holds 1234 this frame, shows 2222 next frame.
  task automatic test_last_wins();
    int pos, d;
    wait_frame();
    step(1);
    for (int c = 0; c < 32; c++) begin
      bus.load     = (c == 3) || (c == 10);
      bus.value_in = (c == 3) ? 16'h1111 : 16'h2222;
      pos = c % 8;
      d   = c / 8;
      if (pos == 4) begin
        n_cmp++;
        if (bus.bcd_out !== nib(16'h1234, d)) begin n_err++; $display("FAIL tear_bcd d=%0d: got %h want %h", d, bus.bcd_out, nib(16'h1234, d)); end
      end
      if (c == 31) begin
        n_cmp++;
        if (bus.frame_done !== 1'b1) begin n_err++; $display("FAIL last_fd: got %b want 1", bus.frame_done); end
      end
      step(1);
    end
    bus.load = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if ((c % 8) == 4) begin
        d = c / 8;
        n_cmp += 2;
        if (bus.bcd_out !== 4'h2)     begin n_err++; $display("FAIL last_bcd d=%0d: got %h want 2", d, bus.bcd_out); end
        if (bus.an_n !== onehot_n(d)) begin n_err++; $display("FAIL last_an d=%0d: got %b want %b", d, bus.an_n, onehot_n(d)); end
      end
      step(1);
    end
  endtask

  // Leading-zero blank of value 0040: digits 3,2 dark, 1 shows 4, 0 shows 0.
  task automatic test_lz_value();
    logic [3:0] e_an [4];
    logic [3:0] e_bcd [4];
    int d;
    e_an[0] = 4'b1110; e_an[1] = 4'b1101; e_an[2] = 4'b1111; e_an[3] = 4'b1111;
    e_bcd[0] = 4'h0;   e_bcd[1] = 4'h4;   e_bcd[2] = 4'hF;   e_bcd[3] = 4'hF;
    bus.blank_lz = 1'b1;
    wait_frame();
    step(1);
    pulse_load(16'h0040, 4'b0000);
    wait_frame();
    step(1);
    for (int c = 0; c < 32; c++) begin
      d = c / 8;
      if ((c % 8) == 4 || ((c % 8) == 0 && d >= 2)) begin
        n_cmp += 3;
        if (bus.an_n !== e_an[d])   begin n_err++; $display("FAIL lz_an c=%0d: got %b want %b", c, bus.an_n, e_an[d]); end
        if (bus.bcd_out !== e_bcd[d]) begin n_err++; $display("FAIL lz_bcd c=%0d: got %h want %h", c, bus.bcd_out, e_bcd[d]); end
        if (bus.dp_n !== 1'b1)      begin n_err++; $display("FAIL lz_dp c=%0d: got %b want 1", c, bus.dp_n); end
      end
      step(1);
    end
  endtask

  // Zero value with dp on digit 2: dp keeps digit 2 and below lit; digit 3 dark.
  task automatic test_lz_dp();
    logic [3:0] e_an [4];
    logic [3:0] e_bcd [4];
    logic       e_dp [4];
    int d;
    e_an[0] = 4'b1110; e_an[1] = 4'b1101; e_an[2] = 4'b1011; e_an[3] = 4'b1111;
    e_bcd[0] = 4'h0;   e_bcd[1] = 4'h0;   e_bcd[2] = 4'h0;   e_bcd[3] = 4'hF;
    e_dp[0] = 1'b1;    e_dp[1] = 1'b1;    e_dp[2] = 1'b0;    e_dp[3] = 1'b1;
    wait_frame();
    step(1);
    pulse_load(16'h0000, 4'b0100);
    wait_frame();
    step(1);
    for (int c = 0; c < 32; c++) begin
      d = c / 8;
      if ((c % 8) == 4) begin
        n_cmp += 3;
        if (bus.an_n !== e_an[d])     begin n_err++; $display("FAIL lzdp_an d=%0d: got %b want %b", d, bus.an_n, e_an[d]); end
        if (bus.bcd_out !== e_bcd[d]) begin n_err++; $display("FAIL lzdp_bcd d=%0d: got %h want %h", d, bus.bcd_out, e_bcd[d]); end
        if (bus.dp_n !== e_dp[d])     begin n_err++; $display("FAIL lzdp_dp d=%0d: got %b want %b", d, bus.dp_n, e_dp[d]); end
      end
      step(1);
    end
    bus.blank_lz = 1'b0;
  endtask

  // Load on the commit cycle itself shows from digit 0 of the very next frame.
  task automatic test_commit_bypass();
    logic e_dp;
    int d;
    wait_frame();
    wait_frame();
    pulse_load(16'h5678, 4'b0001);
    n_cmp += 3;
    if (bus.bcd_out !== 4'h8) begin n_err++; $display("FAIL byp_bcd0: got %h want 8", bus.bcd_out); end
    if (bus.dp_n !== 1'b0)    begin n_err++; $display("FAIL byp_dp0: got %b want 0", bus.dp_n); end
    if (bus.an_n !== 4'hF)    begin n_err++; $display("FAIL byp_an0: got %b want 1111", bus.an_n); end
    for (int c = 0; c < 32; c++) begin
      d = c / 8;
      e_dp = (d != 0);
      if ((c % 8) == 4) begin
        n_cmp += 3;
        if (bus.bcd_out !== nib(16'h5678, d)) begin n_err++; $display("FAIL byp_bcd d=%0d: got %h want %h", d, bus.bcd_out, nib(16'h5678, d)); end
        if (bus.an_n !== onehot_n(d))         begin n_err++; $display("FAIL byp_an d=%0d: got %b want %b", d, bus.an_n, onehot_n(d)); end
        if (bus.dp_n !== e_dp)                begin n_err++; $display("FAIL byp_dp d=%0d: got %b want %b", d, bus.dp_n, e_dp); end
      end
      step(1);
    end
  endtask

  // Reset during ON darkens anodes without a clock edge and discards the pending load.
  task automatic test_reset_mid_on();
    wait_frame();
    step(1);
    pulse_load(16'h9999, 4'b1111);
    step(3);
    n_cmp += 2;
    if (bus.an_n !== 4'b1110) begin n_err++; $display("FAIL mid_pre_an: got %b want 1110", bus.an_n); end
    if (bus.bcd_out !== 4'h8) begin n_err++; $display("FAIL mid_pre_bcd: got %h want 8", bus.bcd_out); end
    rst = 1'b1;
    #1;
    n_cmp += 3;
    if (bus.an_n !== 4'hF)    begin n_err++; $display("FAIL mid_rst_an: got %b want 1111", bus.an_n); end
    if (bus.bcd_out !== 4'hF) begin n_err++; $display("FAIL mid_rst_bcd: got %h want f", bus.bcd_out); end
    if (bus.dp_n !== 1'b1)    begin n_err++; $display("FAIL mid_rst_dp: got %b want 1", bus.dp_n); end
    @(negedge clk);
    rst = 1'b0;
    step(2);
    n_cmp += 2;
    if (bus.an_n !== 4'b1110) begin n_err++; $display("FAIL mid_post_an: got %b want 1110", bus.an_n); end
    if (bus.bcd_out !== 4'h0) begin n_err++; $display("FAIL mid_post_bcd: got %h want 0", bus.bcd_out); end
    wait_frame();
    step(1);
    n_cmp += 2;
    if (bus.bcd_out !== 4'h0) begin n_err++; $display("FAIL mid_lost_bcd: got %h want 0", bus.bcd_out); end
    if (bus.dp_n !== 1'b1)    begin n_err++; $display("FAIL mid_lost_dp: got %b want 1", bus.dp_n); end
  endtask

  // scoreboard-style sequencing and final report
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    @(negedge clk);
    test_reset();
    test_scan_load();
    test_last_wins();
    test_lz_value();
    test_lz_dp();
    test_commit_bypass();
    test_reset_mid_on();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
